// File: rtl/valve_pwm_bank.sv
// valve_pwm_bank: N-channel 50 Hz servo valve driver with frame-aligned pulse-width updates.
// Define VALVE_SLEW_EN to ramp each pulse width by STEP_US per frame instead of jumping.
module valve_pwm_bank #(
    parameter int NUM_CH    = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int PERIOD_US = 20000,
    parameter int CLOSED_US = 1000,
    parameter int OPEN_US   = 2000,
    parameter int STEP_US   = 50,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic              cmd_open,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] settled,
    output logic              frame_start
);
    localparam int PRE = CLK_HZ / 1_000_000;
    localparam int PSW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int FW  = $clog2(PERIOD_US);
    localparam logic [FW-1:0] W_CLOSED = FW'(CLOSED_US);
    localparam logic [FW-1:0] W_OPEN   = FW'(OPEN_US);

    if (CLK_HZ % 1_000_000 != 0 || PRE < 1 || NUM_CH < 1 || NUM_CH > 16 || STEP_US < 1 ||
        !(CLOSED_US < OPEN_US && OPEN_US < PERIOD_US)) begin : g_bad_params
        $error("valve_pwm_bank: invalid parameter set");
    end

    logic [PSW-1:0]    psc;
    logic [FW-1:0]     fcnt;
    logic              us_tick, wrap, acc, ch_ok;
    logic [NUM_CH-1:0] tgt, tgt_nxt;
    logic [FW-1:0]     pw     [NUM_CH];
    logic [FW-1:0]     pw_nxt [NUM_CH];
    logic [FW-1:0]     tw     [NUM_CH];

`ifdef VALVE_SLEW_EN
    localparam logic [FW-1:0] W_STEP = FW'(STEP_US);
    function automatic logic [FW-1:0] slew(input logic [FW-1:0] cur, input logic [FW-1:0] dst);
        return (cur < dst) ? ((dst - cur <= W_STEP) ? dst : cur + W_STEP)
                           : ((cur - dst <= W_STEP) ? dst : cur - W_STEP);
    endfunction
`endif

    assign us_tick = psc == PSW'(PRE - 1);
    assign wrap    = us_tick && fcnt == FW'(PERIOD_US - 1);
    assign acc     = cmd_valid && cmd_ready;
    assign ch_ok   = int'(cmd_ch) < NUM_CH;

    // tgt_nxt folds in this cycle's command so a command on the wrap edge lands in that wrap
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_nxt[i] = (acc && ch_ok && int'(cmd_ch) == i) ? cmd_open : tgt[i];
            tw[i]      = tgt[i] ? W_OPEN : W_CLOSED;
`ifdef VALVE_SLEW_EN
            pw_nxt[i]  = slew(pw[i], tgt_nxt[i] ? W_OPEN : W_CLOSED);
`else
            pw_nxt[i]  = tgt_nxt[i] ? W_OPEN : W_CLOSED;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc         <= '0;
            fcnt        <= '0;
            cmd_ready   <= 1'b0;
            cmd_err     <= 1'b0;
            frame_start <= 1'b0;
            pwm         <= '0;
            settled     <= '1;
            tgt         <= '0;
            for (int i = 0; i < NUM_CH; i++) pw[i] <= W_CLOSED;
        end else begin
            psc         <= us_tick ? '0 : psc + 1'b1;
            if (us_tick) fcnt <= wrap ? '0 : fcnt + 1'b1;
            cmd_ready   <= 1'b1;
            cmd_err     <= acc && !ch_ok;
            frame_start <= wrap;
            tgt         <= tgt_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm[i]     <= fcnt < pw[i];
                settled[i] <= pw[i] == tw[i];
                if (wrap) pw[i] <= pw_nxt[i];
            end
        end
    end
endmodule
